// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator and the sequence detector:
// symbol table, sequence length and the common FSM state encoding.
package seq_pkg;

    localparam logic [7:0] SYM_ONE   = 8'h31;
    localparam logic [7:0] SYM_TWO   = 8'h32;
    localparam logic [7:0] SYM_THREE = 8'h33;

    localparam int SEQ_LEN = 5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYM0 = 3'd1;
    localparam logic [2:0] ST_SYM1 = 3'd2;
    localparam logic [2:0] ST_SYM2 = 3'd3;
    localparam logic [2:0] ST_SYM3 = 3'd4;
    localparam logic [2:0] ST_SYM4 = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_SYM0 = ST_SYM0,
        S_SYM1 = ST_SYM1,
        S_SYM2 = ST_SYM2,
        S_SYM3 = ST_SYM3,
        S_SYM4 = ST_SYM4,
        S_DONE = ST_DONE
    } state_e;

    // Table entry for sequence position 0..4: "1","2","1","3","1".
    function automatic logic [7:0] seq_symbol(input logic [2:0] index);
        logic [7:0] sym;
        case (index)
            3'd1:    sym = SYM_TWO;
            3'd3:    sym = SYM_THREE;
            default: sym = SYM_ONE;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/seq_gen.sv
// Symbol sequence generator: emits "1","2","1","3","1" count times over a
// valid/ready stream, then pulses done for one cycle.
module seq_gen
    import seq_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_SYMBOL = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [3:0]            count,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_symbol,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    state_e                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_out_symbol;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;

    function automatic logic [DATA_WIDTH-1:0] sym_at(input logic [2:0] index);
        return DATA_WIDTH'(seq_symbol(index));
    endfunction

    // FSM with registered outputs; outputs are loaded alongside the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_out_symbol <= IDLE_SYMBOL;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (count != 4'd0) begin
                            r_state      <= S_SYM0;
                            r_cnt        <= count;
                            r_out_valid  <= 1'b1;
                            r_out_symbol <= sym_at(3'd0);
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b0;
                    end
                end
                S_SYM0, S_SYM1, S_SYM2, S_SYM3: begin
                    // SYMn has encoding n+1, which is also the index of the next symbol.
                    if (out_ready) begin
                        r_state      <= state_e'(r_state + 3'd1);
                        r_out_symbol <= sym_at(r_state);
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_SYM4: begin
                    if (out_ready) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt != 4'd1) begin
                            r_state      <= S_SYM0;
                            r_out_symbol <= sym_at(3'd0);
                        end else begin
                            r_state      <= S_DONE;
                            r_out_valid  <= 1'b0;
                            r_out_symbol <= IDLE_SYMBOL;
                            r_done       <= 1'b1;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= 4'd0;
                    r_out_symbol <= IDLE_SYMBOL;
                    r_out_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign out_symbol = r_out_symbol;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_seq_gen.sv
// Randomized scoreboard bench for seq_gen: stimulus pushes the expected symbol
// stream, an independent monitor pops and compares on every handshake.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] count;
    logic       out_ready;
    logic [7:0] out_symbol;
    logic       out_valid;
    logic       busy;
    logic       done;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         exp_done = 0;
    logic [7:0] pattern[5] = '{8'h31, 8'h32, 8'h31, 8'h33, 8'h31};

    always #5 clk = ~clk;

    seq_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .count      (count),
        .out_ready  (out_ready),
        .out_symbol (out_symbol),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(cyc >= 2 && cyc <= 4);
        return 1'b1;
    endfunction

    // Monitor: compares handshakes and done pulses against the scoreboard.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_sym;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_sym   = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_symbol", out_symbol, prev_sym);
                end
                if (!out_valid) check("idle_symbol", out_symbol, 8'h00);
                if (out_valid) check("busy_while_valid", busy, 1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("extra_symbol");
                    end else begin
                        e = exp_q.pop_front();
                        check("symbol", out_symbol, e);
                    end
                end
                if (done) begin
                    check("done_busy", busy, 1);
                    check("done_valid", out_valid, 0);
                    if (exp_done == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        check("done_pending_symbols", exp_q.size(), 0);
                        exp_done--;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_sym   = out_symbol;
            end
        end
    end

    // One transaction; entered and left just after a rising edge.
    task automatic run_txn(input logic [3:0] n, input int mode);
        bit got;
        int cyc;
        got = 1'b0;
        cyc = 0;
        start     = 1'b1;
        count     = n;
        out_ready = ready_for(mode, 0);
        for (int r = 0; r < n; r++)
            for (int s = 0; s < 5; s++) exp_q.push_back(pattern[s]);
        exp_done++;
        @(posedge clk); #1;
        start     = 1'b0;
        count     = 4'($urandom);
        out_ready = ready_for(mode, 0);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (n != 4'd0) begin
                    check("start_latency_valid", out_valid, 1);
                    check("start_latency_busy", busy, 1);
                end else begin
                    check("zero_count_done", done, 1);
                    check("zero_count_busy", busy, 1);
                    check("zero_count_valid", out_valid, 0);
                end
            end
            if (mode == 2 && i >= 2 && i <= 4) begin
                check("bp_valid", out_valid, 1);
                check("bp_symbol", out_symbol, 8'h31);
            end
            if (done) begin
                got = 1'b1;
                cyc = i;
                break;
            end
            @(posedge clk); #1;
            out_ready = ready_for(mode, i + 1);
            start     = (mode == 1) ? (busy & 1'($urandom)) : busy;
            count     = 4'($urandom);
        end
        if (!got) fail_now("done_timeout");
        if (got && mode == 0) check("throughput_cycles", cyc, 5 * n);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("after_done_busy", busy, 0);
        check("after_done_done", done, 0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_op();
        start     = 1'b1;
        count     = 4'd1;
        out_ready = 1'b1;
        for (int s = 0; s < 5; s++) exp_q.push_back(pattern[s]);
        exp_done++;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_sym3", out_symbol, 8'h33);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_symbol", out_symbol, 8'h00);
        check("async_reset_busy", busy, 0);
        check("async_reset_done", done, 0);
        exp_q.delete();
        exp_done = 0;
        repeat (2) begin
            @(negedge clk);
            check("in_reset_done", done, 0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_done", done, 0);
        check("post_reset_valid", out_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        count     = 4'd0;
        out_ready = 1'b0;
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_symbol", out_symbol, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        @(posedge clk); #1;

        run_txn(4'd1, 0);
        run_txn(4'd1, 2);
        run_txn(4'd3, 0);
        run_txn(4'd0, 0);
        reset_mid_op();
        run_txn(4'd1, 0);
        for (int t = 0; t < 25; t++) run_txn(4'($urandom_range(0, 15)), 1);
        run_txn(4'd15, 0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_outstanding", exp_done, 0);
        check("final_idle_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
# seq_gen

Symbol sequence generator: the transmit side of the sequence-detector interface. On a start request it emits the fixed 5-symbol sequence "1","2","1","3","1" (ASCII 0x31, 0x32, 0x31, 0x33, 0x31) one symbol per accepted transfer, repeated a programmable number of times. It sits upstream of `seq`, driving that block's `in_symbol` bus. It also serves as the stimulus source for detector system tests.

## Interface
- `DATA_WIDTH`, 8: symbol bus width. Minimum 2. Symbols are truncated to the low `DATA_WIDTH` bits, so they stay distinct and nonzero.
- `IDLE_SYMBOL`, 0: value driven on `out_symbol` whenever `out_valid` is low.
- `clk`  in  1: single clock, rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to begin transmission. Sampled only in IDLE.
- `count`  in  4: number of sequence repetitions. Latched when `start` is accepted.
- `out_ready`  in  1: downstream accepts the current symbol this cycle.
- `out_symbol`  out  DATA_WIDTH: current symbol. Registered.
- `out_valid`  out  1: `out_symbol` holds a sequence symbol. Registered.
- `busy`  out  1: high from the accepted start until the end of the DONE cycle.
- `done`  out  1: one-cycle pulse after the final symbol handshake.

## Operation
- FSM uses 3-bit binary encoding:
  - IDLE = 0
  - SYM0..SYM4 = 1..5
  - DONE = 6
  - Encoding 7 is illegal and recovers to IDLE.
- IDLE:
  - `start` = 1 with `count` != 0 goes to SYM0 and loads the remaining-repetitions counter with `count`.
  - `start` = 1 with `count` = 0 goes directly to DONE. No symbols are emitted, but `done` still pulses.
- SYMn:
  - `out_valid` = 1 and `out_symbol` = table[n].
  - Advance only on a handshake (`out_valid` && `out_ready`).
  - On a SYM4 handshake, decrement the counter. If the remainder is nonzero, go to SYM0 back-to-back with no idle gap. Otherwise go to DONE.
- DONE: `done` = 1 and `busy` = 1 for exactly one cycle, then IDLE.
- Backpressure: while `out_ready` = 0, `out_symbol`, `out_valid` and the state hold stable. `out_valid` never drops once raised until that symbol is accepted.
- `start` is ignored in every state other than IDLE, including DONE. Changes on `count` after acceptance have no effect.
- `out_valid` = 0 forces `out_symbol` = `IDLE_SYMBOL`.

## Timing
- Reset (asynchronous assert) gives:
  - state IDLE
  - `out_valid` = 0
  - `out_symbol` = `IDLE_SYMBOL`
  - `busy` = 0
  - `done` = 0
  - counter = 0
- Reset deassertion takes effect synchronously at the next edge.
- Reset mid-transmission aborts immediately: no `done` pulse, outputs go to their reset values.
- Start latency: with `start` sampled at edge k, `out_valid` = 1 and `busy` = 1 are visible after edge k.
- Throughput: with `out_ready` held high, one symbol per clock. N repetitions take 5N consecutive valid cycles, and `done` pulses in the cycle after the last symbol.
- `count` = 0: `busy` and `done` are high for the single cycle after edge k.
- When `start` coincides with `out_ready` in IDLE, `out_ready` has no effect because `out_valid` is 0.

## Structure
- Shared package `seq_pkg` holds:
  - 8-bit symbol constants `SYM_ONE` = 8'h31, `SYM_TWO` = 8'h32, `SYM_THREE` = 8'h33
  - `SEQ_LEN` = 5
  - state encoding localparams shared with `seq`
  - function `seq_symbol(index)` returning the table entry
- No sub-module. The FSM, repetition counter and output registers form one module, `seq_gen`.

## Test plan
- Single sequence: `count` = 1, `start` pulse, `out_ready` = 1 → `out_symbol` = 0x31, 0x32, 0x31, 0x33, 0x31 on 5 consecutive cycles, then `done` for 1 cycle, then `busy` = 0.
- Backpressure: `count` = 1, drop `out_ready` for 3 cycles during SYM2 → 0x31 held stable with `out_valid` = 1 for those 3 cycles; the full sequence is still emitted in order.
- Repetition: `count` = 3 with `out_ready` high → 15 back-to-back valid symbols (the pattern three times) and exactly one `done` pulse. Looped into `seq`, `match` asserts after each fifth symbol.
- Zero count: `count` = 0 → `out_valid` never rises; `busy` and `done` are high for one cycle.
- Ignored start: a `start` pulse during SYM1 and during DONE → no restart and no extra symbols.
- Reset mid-op: assert `reset_n` = 0 during SYM3 → outputs reach reset values asynchronously with no `done` pulse. After release, a new `start` emits a complete sequence.
